// File: rtl/dec_pipelined_stream.sv
// Two-stage streaming SEC-DED decoder for 8/16/32/64-bit codewords (4..7 LSB parity bits),
// valid/ready handshake with stall, plus saturating single/double error counters.

// One decoder per codeword mode: syndrome for the incoming word, correction for the S1 word.
module dec_hamming_lane #(
  parameter int W = 32,
  parameter int P = 4,
  parameter int N = 8
) (
  input  logic [N-1:0] cw,
  output logic [6:0]   syn,
  input  logic [N-1:0] s1_cw,
  input  logic [6:0]   s1_syn,
  output logic [W-1:0] data,
  output logic [1:0]   cls
);
  typedef logic [N-1:0][6:0] cols_t;

  // Parity bits take the unit columns; data bits take the odd-weight (>=3) columns in
  // ascending order, so any two-bit error yields an even-weight, non-column syndrome.
  function automatic cols_t cols_init();
    cols_t c;
    int    v;
    c = '0;
    v = 2;
    for (int i = 0; i < N; i++) begin
      if (i < P) c[i] = 7'(1 << i);
      else begin
        v++;
        while (($countones(v) % 2) == 0 || $countones(v) == 1) v++;
        c[i] = 7'(v);
      end
    end
    return c;
  endfunction

  localparam cols_t COLS = cols_init();

  logic [N-1:0] fix;
  logic         hit;

  always_comb begin
    syn = '0;
    for (int i = 0; i < N; i++)
      if (cw[i]) syn = syn ^ COLS[i];
  end

  always_comb begin
    fix = s1_cw;
    hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (s1_syn == COLS[i]) begin
        fix[i] = ~fix[i];
        hit    = 1'b1;
      end
    data = '0;
    data[N-P-1:0] = fix[N-1:P];
    if (s1_syn == '0) cls = 2'd0;
    else if (hit)     cls = 2'd1;
    else              cls = 2'd2;
  end
endmodule

module dec_pipelined_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_codeword,
  input  logic [1:0]             codeword_width,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             num_of_errors,
  input  logic                   clr_cnt,
  output logic [COUNT_WIDTH-1:0] cnt_single,
  output logic [COUNT_WIDTH-1:0] cnt_double
);
  localparam int STAGES    = 2;
  localparam int NUM_MODES = (DATA_WIDTH == 64) ? 4 : 3;

  logic [STAGES:1]                      vld_pipe;
  logic                                 adv, acc, xfer;
  logic [1:0]                           mode, s1_mode;
  logic [DATA_WIDTH-1:0]                s1_cw;
  logic [6:0]                           s1_syn;
  logic [NUM_MODES-1:0][6:0]            lane_syn;
  logic [NUM_MODES-1:0][DATA_WIDTH-1:0] lane_data;
  logic [NUM_MODES-1:0][1:0]            lane_cls;

  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv && enable;
  assign acc       = in_valid && in_ready;
  assign out_valid = vld_pipe[STAGES];
  assign xfer      = vld_pipe[STAGES] && out_ready;
  // A 32-bit build has no 64-bit lane; its mode 11 folds onto the 32-bit lane.
  assign mode      = (NUM_MODES == 3 && codeword_width == 2'd3) ? 2'd2 : codeword_width;

  for (genvar g = 0; g < NUM_MODES; g++) begin : g_lane
    dec_hamming_lane #(.W(DATA_WIDTH), .P(4 + g), .N(8 << g)) u_lane (
      .cw     (in_codeword[(8 << g)-1:0]),
      .syn    (lane_syn[g]),
      .s1_cw  (s1_cw[(8 << g)-1:0]),
      .s1_syn (s1_syn),
      .data   (lane_data[g]),
      .cls    (lane_cls[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe      <= '0;
      s1_cw         <= '0;
      s1_mode       <= '0;
      s1_syn        <= '0;
      out_data      <= '0;
      num_of_errors <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[1], acc};
      if (acc) begin
        s1_cw   <= in_codeword;
        s1_mode <= mode;
        s1_syn  <= lane_syn[mode];
      end
      if (vld_pipe[1]) begin
        out_data      <= lane_data[s1_mode];
        num_of_errors <= lane_cls[s1_mode];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (clr_cnt) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (xfer) begin
      if (num_of_errors == 2'd1 && cnt_single != '1) cnt_single <= cnt_single + COUNT_WIDTH'(1);
      if (num_of_errors == 2'd2 && cnt_double != '1) cnt_double <= cnt_double + COUNT_WIDTH'(1);
    end
  end
endmodule

// File: doc/dec_pipelined_stream.md
DEC_PIPELINED_STREAM -- requirements
Module: dec_pipelined_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the maximum codeword width; legal values are 32 and 64.
REQ-002 Parameter COUNT_WIDTH, default 16, SHALL set the width of the error-statistics counters.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port enable  input  1  SHALL gate input acceptance; while low, in_ready is 0.
REQ-006 Port in_valid  input  1  SHALL flag a codeword presented on in_codeword.
REQ-007 Port in_ready  output  1  SHALL flag that the block accepts in_codeword this cycle.
REQ-008 Port in_codeword  input  DATA_WIDTH  SHALL carry the received codeword, LSB-aligned.
REQ-009 Port codeword_width  input  2  SHALL select the mode and is sampled with in_codeword: 00=8b/4p, 01=16b/5p, 10=32b/6p, 11=64b/7p.
REQ-010 Port out_valid  output  1  SHALL flag a decoded result on out_data/num_of_errors.
REQ-011 Port out_ready  input  1  SHALL flag that the consumer accepts the result.
REQ-012 Port out_data  output  DATA_WIDTH  SHALL carry the data bits, right-justified and zero-extended.
REQ-013 Port num_of_errors  output  2  SHALL report the classification: 0=clean, 1=single corrected, 2=uncorrectable.
REQ-014 Port clr_cnt  input  1  SHALL synchronously clear both counters.
REQ-015 Port cnt_single  output  COUNT_WIDTH  SHALL count transfers with num_of_errors=1.
REQ-016 Port cnt_double  output  COUNT_WIDTH  SHALL count transfers with num_of_errors=2.

Function
REQ-017 Parity bits SHALL occupy codeword LSBs, with data above them; the parity-check matrices SHALL be the team's standard per-mode Hamming matrices, identical to the encoder's.
REQ-018 When DATA_WIDTH=32, mode 11 SHALL be decoded as mode 10.
REQ-019 Codeword bits above the selected mode width SHALL be ignored.
REQ-020 Input handshake: a transfer occurs when in_valid and in_ready are both high; the mode is captured in the same cycle.
REQ-021 Pipeline: stage S1 SHALL register the codeword, mode and syndrome; stage S2 SHALL register the classification, the corrected data and out_valid.
REQ-022 Advance condition adv = !out_valid || out_ready; S1 and S2 SHALL advance only when adv is high.
REQ-023 in_ready SHALL equal adv && enable, combinationally.
REQ-024 With no stall, latency SHALL be 2 cycles from the accepting edge to out_valid.
REQ-025 Sustained throughput SHALL be one codeword per cycle.
REQ-026 While out_valid && !out_ready, out_data, num_of_errors and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-027 Syndrome = 0 SHALL give num_of_errors=0 and the data unchanged.
REQ-028 A syndrome equal to a column of H SHALL give num_of_errors=1, with that bit flipped before extraction; a flipped parity bit leaves the data unchanged.
REQ-029 Any other syndrome SHALL give num_of_errors=2, with the data passed through uncorrected.
REQ-030 Counters SHALL increment only on an output transfer (out_valid && out_ready).
REQ-031 Counters SHALL saturate at all-ones and never wrap.
REQ-032 clr_cnt SHALL take priority over a coincident increment; the counter is 0 on the next cycle.
REQ-033 enable falling mid-stream SHALL NOT flush S1 or S2; in-flight results drain normally.
REQ-034 An empty S1 advancing SHALL clear S2's valid bit; bubbles propagate without counting.

Reset
REQ-035 On rst low, asynchronously: out_valid=0, out_data=0, num_of_errors=0, cnt_single=0, cnt_double=0, and S1 valid=0.
REQ-036 After reset, in_ready SHALL be high on the first cycle that enable is high.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight codewords, with no counter update.

Verification
REQ-038 Clean stream: mode 00, team-encoder codeword for data 4'hA, out_ready=1 -> 2 cycles later out_data=32'h0000000A, num_of_errors=0, counters unchanged.
REQ-039 Single error: mode 10, encoded data 26'h2ABCDEF with codeword bit 17 flipped -> out_data=32'h02ABCDEF, num_of_errors=1, cnt_single=1.
REQ-040 Double error: mode 01, encoded data 11'h5A5 with bits 7 and 12 flipped -> num_of_errors=2, data uncorrected, cnt_double=1.
REQ-041 Backpressure: 4 back-to-back codewords with out_ready low for 3 cycles after the first result -> outputs held stable, in_ready=0 while stalled, all 4 results delivered in order with none lost or duplicated.
REQ-042 Saturation/clear: COUNT_WIDTH=2 with 5 single-error transfers -> cnt_single=3; clr_cnt coincident with a 6th single error -> cnt_single=0.
REQ-043 64-bit mode: DATA_WIDTH=64, mode 11, single error at bit 63 -> corrected 57-bit data, num_of_errors=1; the same stimulus with DATA_WIDTH=32 decodes as mode 10.
